// File: rtl/wshb_sdram_arbiter_pkg.sv
// Shared types and helpers for the two-master Wishbone SDRAM arbiter.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    // Counter width able to hold every value 0..timeout.
    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wshb_sdram_arbiter_if.sv
// Wishbone classic/pipelined bus bundle shared by masters and the SDRAM slave port.
// Latency: none (wires only).
// Backpressure: carried by ack/err/rty returned from the slave side.
interface wshb_sdram_arbiter_if #(
    parameter int ADR_W      = 32,
    parameter int DATA_BYTES = 4
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADR_W-1:0]        adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [DATA_BYTES-1:0]   sel;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wshb_sdram_arbiter_watchdog.sv
// Stall watchdog: counts strobe cycles without termination and flags an abort.
// Latency: fire asserts the cycle after TIMEOUT consecutive unterminated strobe cycles.
// Backpressure: none; fire is only valid while the strobe is still active.
module wshb_arb_watchdog
    import wshb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic active,
    input  logic done,
    output logic fire
);
    localparam int           W     = wd_width(TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] count;
    logic         pend;

    // Stall counter plus one-cycle abort pending flag; the abort cycle itself is not counted.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count <= '0;
            pend  <= 1'b0;
        end else begin
            pend <= active && !done && !pend && (count == LIMIT);
            if (!active || done || pend || (count == LIMIT)) begin
                count <= '0;
            end else if (count != '1) begin
                count <= count + 1'b1;
            end
        end
    end

    // A master that dropped its strobe in the abort cycle gets no error.
    assign fire = pend & active;

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the SDRAM slave port.
// Latency: one cycle from cyc in IDLE to grant; zero added latency on the data phase.
// Backpressure: slave ack/err/rty pass straight back to the owner; watchdog aborts stalls.
module wshb_sdram_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int ADR_W      = 32,
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    wshb_sdram_arbiter_if.slave  m0,
    wshb_sdram_arbiter_if.slave  m1,
    wshb_sdram_arbiter_if.master s,
    output logic [1:0]           gnt,
    output logic                 timeout_evt
);
    arb_state_t              state, state_nxt;
    master_id_t              last, last_nxt;
    logic                    own0, own1;
    logic                    raw_stb;
    logic                    done;
    logic                    fire;
    logic [ADR_W-1:0]        adr_mux;
    logic [8*DATA_BYTES-1:0] dat_mux;
    logic [DATA_BYTES-1:0]   sel_mux;

    // Owner state and last owner; last starts at 1 so master 0 wins the first tie.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Grant decisions: tie goes to the master that did not own last; handoff on cyc release.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_nxt = (last == 1'b1) ? OWN0 : OWN1;
                end else if (m0.cyc) begin
                    state_nxt = OWN0;
                end else if (m1.cyc) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!m0.cyc) begin
                    last_nxt  = 1'b0;
                    state_nxt = m1.cyc ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1.cyc) begin
                    last_nxt  = 1'b1;
                    state_nxt = m0.cyc ? OWN0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);
    assign gnt  = {own1, own0};

    // Route the owner's request to the slave; everything is zero while idle.
    always_comb begin
        s.cyc   = 1'b0;
        raw_stb = 1'b0;
        s.we    = 1'b0;
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        s.cti   = '0;
        s.bte   = '0;
        if (own0) begin
            s.cyc   = m0.cyc;
            raw_stb = m0.cyc & m0.stb;
            s.we    = m0.we;
            adr_mux = m0.adr;
            dat_mux = m0.dat_ms;
            sel_mux = m0.sel;
            s.cti   = m0.cti;
            s.bte   = m0.bte;
        end else if (own1) begin
            s.cyc   = m1.cyc;
            raw_stb = m1.cyc & m1.stb;
            s.we    = m1.we;
            adr_mux = m1.adr;
            dat_mux = m1.dat_ms;
            sel_mux = m1.sel;
            s.cti   = m1.cti;
            s.bte   = m1.bte;
        end
    end

    // The abort cycle withdraws the strobe so the slave sees the transfer cancelled.
    assign s.stb    = raw_stb & ~fire;
    assign s.adr    = adr_mux;
    assign s.dat_ms = dat_mux;
    assign s.sel    = sel_mux;
    assign done     = s.ack | s.err | s.rty;

    wshb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .active    (raw_stb),
        .done      (done),
        .fire      (fire)
    );

    // Terminations go to the owner only; a late ack beats the watchdog abort.
    always_comb begin
        timeout_evt = fire & ~s.ack;
        m0.ack      = own0 & s.ack;
        m0.err      = own0 & (s.err | timeout_evt);
        m0.rty      = own0 & s.rty;
        m1.ack      = own1 & s.ack;
        m1.err      = own1 & (s.err | timeout_evt);
        m1.rty      = own1 & s.rty;
        m0.dat_sm   = s.dat_sm;
        m1.dat_sm   = s.dat_sm;
    end

endmodule

// File: doc/wshb_sdram_arbiter.md
Name: wshb_sdram_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter in the sys_clk domain, in front of the hw_support SDRAM slave port.
- Master 0 is the VGA frame-buffer reader, which has priority need. Master 1 is the pattern/stream writer.
- Fair round-robin grant, held for a whole cyc; handoff on cyc release.
- Watchdog returns err to the granted master if the slave stalls.

Parameters:
- ADR_W, 32, address width of masters and slave.
- DATA_BYTES, 4, data bus bytes; data width = 8*DATA_BYTES, sel width = DATA_BYTES.
- TIMEOUT, 255, max cycles an outstanding stb may wait for ack/err/rty before abort; legal range 2..65535.

Ports:
- sys_clk  input  1  system clock, 100 MHz.
- sys_rst_n  input  1  asynchronous, active-low reset.
- m0_cyc, m1_cyc  input  1  master cycle request.
- m0_stb, m1_stb  input  1  master strobe.
- m0_we, m1_we  input  1  write enable.
- m0_adr, m1_adr  input  ADR_W  address.
- m0_dat_ms, m1_dat_ms  input  8*DATA_BYTES  write data.
- m0_sel, m1_sel  input  DATA_BYTES  byte selects.
- m0_cti, m1_cti  input  3  cycle type.
- m0_bte, m1_bte  input  2  burst type.
- m0_ack, m1_ack, m0_err, m1_err, m0_rty, m1_rty  output  1  per-master termination.
- m0_dat_sm, m1_dat_sm  output  8*DATA_BYTES  read data, driven from s_dat_sm to both masters.
- s_cyc, s_stb, s_we  output  1  slave side.
- s_adr  output  ADR_W.
- s_dat_ms  output  8*DATA_BYTES.
- s_sel  output  DATA_BYTES.
- s_cti  output  3.
- s_bte  output  2.
- s_ack, s_err, s_rty  input  1  slave termination.
- s_dat_sm  input  8*DATA_BYTES  slave read data.
- gnt  output  2  one-hot current owner; 00 when idle.
- timeout_evt  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Registered state; `last` register holds the id of the last owner.
- Reset (sys_rst_n=0, asynchronous):
  - State=IDLE, last=1, so master 0 wins the first tie.
  - Watchdog count=0, timeout_evt=0.
  - All s_* control outputs 0 and all m*_ack/err/rty 0 immediately, since they are decoded from state.
- IDLE:
  - s_cyc=s_stb=0.
  - Only m0_cyc high -> OWN0. Only m1_cyc high -> OWN1.
  - Both high -> the master with id != last.
  - Grant latency: 1 cycle from cyc high in IDLE to s_cyc high.
- OWNx:
  - s_cyc/stb/we/adr/dat_ms/sel/cti/bte = mx_* combinationally.
  - mx_ack/err/rty = s_ack/err/rty. The non-owner's ack/err/rty are forced 0.
  - Zero added latency on the data phase; pipelined/burst cycles pass through unchanged.
- Leaving OWNx, when mx_cyc=0:
  - last<=x.
  - If the other master's cyc is high -> OWNy directly, with no idle cycle.
  - Otherwise -> IDLE.
- No preemption: a master may hold the bus indefinitely while cyc stays high; fairness is per cyc.
- While in OWNx, s_* reflects mx_* only while mx_cyc=1; on the release cycle s_cyc follows mx_cyc=0.
- Watchdog:
  - Counts cycles with s_cyc&s_stb&!s_ack&!s_err&!s_rty.
  - Clears on any termination or when s_stb=0.
  - Saturating, width clog2(TIMEOUT+1).
  - When count==TIMEOUT-1 and still no termination:
    - next cycle asserts mx_err=1, timeout_evt=1, and s_stb forced 0 for that cycle;
    - count clears.
    - The master must then drop cyc or retry.
- Simultaneous events:
  - s_ack in the same cycle the watchdog fires: ack wins, no err, no timeout_evt.
  - s_err and s_ack both high: both passed through unchanged (slave bug, not filtered).
- mx_stb high with mx_cyc low is ignored: no grant.
- Mid-transaction reset: the slave sees s_cyc drop asynchronously. Outstanding data is not recovered.

Decomposition:
- Package wshb_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  - typedef logic master_id_t;
  - function clog2-based watchdog width.
- Sub-module wshb_arb_watchdog, parameter TIMEOUT:
  - inputs sys_clk, sys_rst_n, active, done;
  - output fire.
- Mux and FSM stay in the top module.

Test Plan:
- Reset release, m0_cyc=m1_cyc=1 on the same edge -> gnt=01 one cycle later; m1 served after m0 drops cyc, with no IDLE cycle between (gnt 01->10 directly).
- m1 alone performs 4 single reads with addr 0x100..0x10C, slave acks after 2 waits -> m1_ack matches s_ack exactly, m1_dat_sm=s_dat_sm, m0_ack stays 0.
- Alternating contention, both masters reissue cyc immediately after release, 10 rounds -> grants strictly alternate 0,1,0,1…; neither master waits more than one other cyc.
- TIMEOUT=8, slave never acks m0 stb -> m0_err=1 and timeout_evt=1 on the 9th stb cycle, single-cycle pulse, s_stb=0 that cycle.
- Slave acks exactly on the cycle the watchdog would fire -> m0_ack=1, m0_err=0, timeout_evt=0.
- sys_rst_n pulled low mid-burst (cti=010) while OWN1 -> s_cyc=0 and gnt=00 without waiting for a clock edge; after release, a pending m0 request is granted first (last=1).
